// File: rtl/aes_pkg.sv
// Shared constants and helpers for the AES-128 input datapath.
//   AES_BLOCK_W / AES_KEY_W : block and key widths in bits
//   idx_width(data_w)       : width of a word index covering 128/data_w words
package aes_pkg;

    localparam int unsigned AES_BLOCK_W = 128;
    localparam int unsigned AES_KEY_W   = 128;

    // Word-index width for a group of AES_BLOCK_W/data_w words (at least 1 bit).
    function automatic int unsigned idx_width(input int unsigned data_w);
        int unsigned nw;
        nw = AES_BLOCK_W / data_w;
        return (nw > 1) ? $clog2(nw) : 1;
    endfunction

endpackage

// File: rtl/aes_word_assembler.sv
// DATA_W -> 128-bit slice writer shared by the key and plaintext paths.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   clear        : return the word index to 0 (partial words are abandoned)
//   wr_en        : write wr_data at the current (or restarted) index
//   wr_restart   : treat this write as word 0 of a new group
//   wr_data      : incoming word; word k lands in bits [127-k*DATA_W -: DATA_W]
//   idx          : registered word index of the next write
//   first_c      : this write is word 0 of its group
//   last_c       : this write completes the group
//   full_c       : assembled group including this cycle's word
module aes_word_assembler
    import aes_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    localparam int unsigned NW    = AES_BLOCK_W / DATA_W,
    localparam int unsigned IDX_W = idx_width(DATA_W)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic                   wr_en,
    input  logic                   wr_restart,
    input  logic [DATA_W-1:0]      wr_data,
    output logic [IDX_W-1:0]       idx,
    output logic                   first_c,
    output logic                   last_c,
    output logic [AES_BLOCK_W-1:0] full_c
);

    logic [IDX_W-1:0]             idx_q, idx_d;
    logic [NW-1:0][DATA_W-1:0]    words_q, words_d;
    logic [NW-1:0][DATA_W-1:0]    words_full;
    logic [IDX_W-1:0]             eff_idx;

    // Effective index of this write; a restart forces word 0.
    assign eff_idx = wr_restart ? '0 : idx_q;
    assign first_c = (eff_idx == '0);
    assign last_c  = (eff_idx == IDX_W'(NW - 1));
    assign idx     = idx_q;
    assign full_c  = AES_BLOCK_W'(words_full);

    // Word 0 is the most significant slice, hence the reversed packed index.
    always_comb begin
        words_full = words_q;
        words_full[IDX_W'(NW - 1) - eff_idx] = wr_data;
        words_d = words_q;
        idx_d   = idx_q;
        if (wr_en) begin
            words_d = words_full;
            idx_d   = last_c ? '0 : eff_idx + IDX_W'(1);
        end
        if (clear) begin
            idx_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q   <= '0;
            words_q <= '0;
        end else begin
            idx_q   <= idx_d;
            words_q <= words_d;
        end
    end

endmodule

// File: rtl/aes_block_packer.sv
// Input stage of the AES-128 datapath: packs a narrow key/plaintext word
// stream into 128-bit groups, holds the current key, and presents
// {plaintext, key} pairs through a one-entry registered output slot.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   flush             : drop partial group and output slot, keep key
//   in_valid/in_ready : input word handshake (in_ready is combinational)
//   in_data           : input word, first word of a group is most significant
//   in_is_key         : word belongs to a key group (1) or plaintext group (0)
//   blk_valid/blk_ready : output slot handshake
//   blk_plaintext     : assembled plaintext block
//   blk_key           : key snapshot taken when the block completed
//   key_loaded        : a full key has been received since reset
//   err_seq           : pulse, group abandoned on a mid-group type change
//   err_nokey         : pulse, plaintext group dropped for lack of a key
module aes_block_packer
    import aes_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_W-1:0]      in_data,
    input  logic                   in_is_key,
    output logic                   blk_valid,
    input  logic                   blk_ready,
    output logic [AES_BLOCK_W-1:0] blk_plaintext,
    output logic [AES_KEY_W-1:0]   blk_key,
    output logic                   key_loaded,
    output logic                   err_seq,
    output logic                   err_nokey
);

    localparam int unsigned NW    = AES_BLOCK_W / DATA_W;
    localparam int unsigned IDX_W = idx_width(DATA_W);

    logic [IDX_W-1:0]       idx;
    logic                   first_c;
    logic                   last_c;
    logic [AES_BLOCK_W-1:0] asm_full_c;

    logic accept_c;
    logic switch_c;
    logic key_done_c;
    logic pt_done_c;

    logic                   grp_key_q, grp_key_d;
    logic [AES_KEY_W-1:0]   key_q, key_d;
    logic                   key_loaded_q, key_loaded_d;
    logic                   blk_valid_q, blk_valid_d;
    logic [AES_BLOCK_W-1:0] blk_pt_q, blk_pt_d;
    logic [AES_KEY_W-1:0]   blk_key_q, blk_key_d;
    logic                   err_seq_q, err_seq_d;
    logic                   err_nokey_q, err_nokey_d;

    // Only the final word of a group can stall, and only behind a full slot.
    assign in_ready   = !((idx == IDX_W'(NW - 1)) && blk_valid_q && !blk_ready);
    assign accept_c   = in_valid && in_ready && !flush;
    assign switch_c   = accept_c && (idx != '0) && (in_is_key != grp_key_q);
    // A switch restarts at word 0, so last_c implies grp type == in_is_key.
    assign key_done_c = accept_c && last_c && in_is_key;
    assign pt_done_c  = accept_c && last_c && !in_is_key;

    aes_word_assembler #(
        .DATA_W (DATA_W)
    ) u_asm (
        .clk        (clk),
        .rst        (rst),
        .clear      (flush),
        .wr_en      (accept_c),
        .wr_restart (switch_c),
        .wr_data    (in_data),
        .idx        (idx),
        .first_c    (first_c),
        .last_c     (last_c),
        .full_c     (asm_full_c)
    );

    // Next-state logic for group type, key register and output slot.
    always_comb begin
        grp_key_d    = grp_key_q;
        key_d        = key_q;
        key_loaded_d = key_loaded_q;
        blk_valid_d  = blk_valid_q;
        blk_pt_d     = blk_pt_q;
        blk_key_d    = blk_key_q;
        err_seq_d    = switch_c;
        err_nokey_d  = pt_done_c && !key_loaded_q;

        if (accept_c && first_c) begin
            grp_key_d = in_is_key;
        end

        if (key_done_c) begin
            key_d        = asm_full_c;
            key_loaded_d = 1'b1;
        end

        if (blk_valid_q && blk_ready) begin
            blk_valid_d = 1'b0;
        end

        // Load after drain so a same-cycle drain and completion keeps the slot full.
        if (pt_done_c && key_loaded_q) begin
            blk_valid_d = 1'b1;
            blk_pt_d    = asm_full_c;
            blk_key_d   = key_q;
        end

        if (flush) begin
            blk_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            grp_key_q    <= 1'b0;
            key_q        <= '0;
            key_loaded_q <= 1'b0;
            blk_valid_q  <= 1'b0;
            blk_pt_q     <= '0;
            blk_key_q    <= '0;
            err_seq_q    <= 1'b0;
            err_nokey_q  <= 1'b0;
        end else begin
            grp_key_q    <= grp_key_d;
            key_q        <= key_d;
            key_loaded_q <= key_loaded_d;
            blk_valid_q  <= blk_valid_d;
            blk_pt_q     <= blk_pt_d;
            blk_key_q    <= blk_key_d;
            err_seq_q    <= err_seq_d;
            err_nokey_q  <= err_nokey_d;
        end
    end

    assign blk_valid     = blk_valid_q;
    assign blk_plaintext = blk_pt_q;
    assign blk_key       = blk_key_q;
    assign key_loaded    = key_loaded_q;
    assign err_seq       = err_seq_q;
    assign err_nokey     = err_nokey_q;

endmodule

// File: tb/tb_aes_block_packer.sv
// Bench for aes_block_packer: 32-bit and 8-bit instances, scoreboard of
// expected {plaintext, key} blocks popped on each output handshake.
module tb_aes_block_packer;

    localparam logic [127:0] KEY1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] KEY2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] PT2  = 128'hffeeddccbbaa99887766554433221100;

    logic         clk = 1'b0;
    always #5 clk = ~clk;

    // 32-bit instance
    logic         rst, flush, in_valid, in_ready, in_is_key;
    logic [31:0]  in_data;
    logic         blk_valid, blk_ready, key_loaded, err_seq, err_nokey;
    logic [127:0] blk_plaintext, blk_key;

    // 8-bit instance
    logic         b_rst, b_flush, b_in_valid, b_in_ready, b_in_is_key;
    logic [7:0]   b_in_data;
    logic         b_blk_valid, b_blk_ready, b_key_loaded, b_err_seq, b_err_nokey;
    logic [127:0] b_blk_plaintext, b_blk_key;

    int n_pass  = 0;
    int n_total = 0;

    logic [255:0] sb32[$];
    logic [255:0] sb8[$];
    time          pop8_t[$];

    aes_block_packer #(.DATA_W(32)) dut32 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_is_key(in_is_key),
        .blk_valid(blk_valid), .blk_ready(blk_ready),
        .blk_plaintext(blk_plaintext), .blk_key(blk_key),
        .key_loaded(key_loaded), .err_seq(err_seq), .err_nokey(err_nokey)
    );

    aes_block_packer #(.DATA_W(8)) dut8 (
        .clk(clk), .rst(b_rst), .flush(b_flush),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_is_key(b_in_is_key),
        .blk_valid(b_blk_valid), .blk_ready(b_blk_ready),
        .blk_plaintext(b_blk_plaintext), .blk_key(b_blk_key),
        .key_loaded(b_key_loaded), .err_seq(b_err_seq), .err_nokey(b_err_nokey)
    );

    // Scoreboard: every output handshake must match the oldest expected block.
    always @(negedge clk) begin
        logic [255:0] exp;
        if (!rst && blk_valid && blk_ready) begin
            n_total++;
            if (sb32.size() == 0) begin
                $display("FAIL sb32_unexpected: got pt=%h key=%h, required none", blk_plaintext, blk_key);
            end else begin
                exp = sb32.pop_front();
                if ({blk_plaintext, blk_key} !== exp)
                    $display("FAIL sb32_block: got pt=%h key=%h, required pt=%h key=%h",
                             blk_plaintext, blk_key, exp[255:128], exp[127:0]);
                else n_pass++;
            end
        end
    end

    always @(negedge clk) begin
        logic [255:0] exp;
        if (!b_rst && b_blk_valid && b_blk_ready) begin
            n_total++;
            pop8_t.push_back($time);
            if (sb8.size() == 0) begin
                $display("FAIL sb8_unexpected: got pt=%h key=%h, required none", b_blk_plaintext, b_blk_key);
            end else begin
                exp = sb8.pop_front();
                if ({b_blk_plaintext, b_blk_key} !== exp)
                    $display("FAIL sb8_block: got pt=%h key=%h, required pt=%h key=%h",
                             b_blk_plaintext, b_blk_key, exp[255:128], exp[127:0]);
                else n_pass++;
            end
        end
    end

    // Drivers: entered at posedge+1, return at posedge+1 after the accepting edge.
    task automatic send_word32(input logic [31:0] d, input logic k);
        int  waited;
        bit  done;
        in_valid = 1'b1; in_data = d; in_is_key = k;
        waited = 0; done = 0;
        while (!done) begin
            @(negedge clk);
            if (in_ready) begin
                done = 1;
            end else begin
                waited++;
                if (waited > 50) begin
                    n_total++;
                    $display("FAIL in_ready_timeout32: in_ready stuck at 0, required 1");
                    done = 1;
                end
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic send_block32(input logic [127:0] v, input logic k);
        for (int i = 0; i < 4; i++) send_word32(v[127-32*i -: 32], k);
    endtask

    task automatic send_word8(input logic [7:0] d, input logic k);
        int  waited;
        bit  done;
        b_in_valid = 1'b1; b_in_data = d; b_in_is_key = k;
        waited = 0; done = 0;
        while (!done) begin
            @(negedge clk);
            if (b_in_ready) begin
                done = 1;
            end else begin
                waited++;
                if (waited > 50) begin
                    n_total++;
                    $display("FAIL in_ready_timeout8: in_ready stuck at 0, required 1");
                    done = 1;
                end
            end
            @(posedge clk); #1;
        end
        b_in_valid = 1'b0;
    endtask

    task automatic send_block8(input logic [127:0] v, input logic k);
        for (int i = 0; i < 16; i++) send_word8(v[127-8*i -: 8], k);
    endtask

    task automatic next_cycle();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; b_rst = 1'b1; flush = 1'b0; b_flush = 1'b0;
        in_valid = 1'b0; in_data = '0; in_is_key = 1'b0; blk_ready = 1'b1;
        b_in_valid = 1'b0; b_in_data = '0; b_in_is_key = 1'b0; b_blk_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1; rst = 1'b0; b_rst = 1'b0;
        @(negedge clk);
        n_total++;
        if ({in_ready, blk_valid, key_loaded, err_seq, err_nokey} !== 5'b10000)
            $display("FAIL reset_flags: got rdy/vld/kl/es/en=%b, required 10000",
                     {in_ready, blk_valid, key_loaded, err_seq, err_nokey});
        else n_pass++;
        n_total++;
        if ({blk_plaintext, blk_key} !== 256'h0)
            $display("FAIL reset_slot: got pt=%h key=%h, required zero", blk_plaintext, blk_key);
        else n_pass++;
        n_total++;
        if ({b_in_ready, b_blk_valid, b_key_loaded} !== 3'b100)
            $display("FAIL reset_flags8: got rdy/vld/kl=%b, required 100", {b_in_ready, b_blk_valid, b_key_loaded});
        else n_pass++;
        next_cycle();
    endtask

    task automatic test_no_key();
        blk_ready = 1'b1;
        send_block32(PT1, 1'b0);
        @(negedge clk);
        n_total++;
        if ({err_nokey, blk_valid, in_ready} !== 3'b101)
            $display("FAIL nokey_pulse: got nokey/vld/rdy=%b, required 101", {err_nokey, blk_valid, in_ready});
        else n_pass++;
        next_cycle();
        @(negedge clk);
        n_total++;
        if (err_nokey !== 1'b0) $display("FAIL nokey_one_cycle: got %b, required 0", err_nokey);
        else n_pass++;
        next_cycle();
    endtask

    task automatic test_key_load();
        send_block32(KEY1, 1'b1);
        @(negedge clk);
        n_total++;
        if ({key_loaded, blk_valid} !== 2'b10)
            $display("FAIL keyload_flags: got kl/vld=%b, required 10", {key_loaded, blk_valid});
        else n_pass++;
        next_cycle();
        blk_ready = 1'b0;
        sb32.push_back({PT1, KEY1});
        send_block32(PT1, 1'b0);
        @(negedge clk);
        n_total++;
        if (blk_valid !== 1'b1) $display("FAIL keyload_latency: got blk_valid=%b, required 1", blk_valid);
        else n_pass++;
        repeat (2) next_cycle();
        @(negedge clk);
        n_total++;
        if ({blk_valid, blk_plaintext, blk_key} !== {1'b1, PT1, KEY1})
            $display("FAIL keyload_hold: got vld=%b pt=%h key=%h, required 1 %h %h",
                     blk_valid, blk_plaintext, blk_key, PT1, KEY1);
        else n_pass++;
        next_cycle();
    endtask

    task automatic test_backpressure();
        logic [127:0] v;
        v = PT2;
        for (int i = 0; i < 3; i++) send_word32(v[127-32*i -: 32], 1'b0);
        in_valid = 1'b1; in_data = v[31:0]; in_is_key = 1'b0;
        @(negedge clk);
        n_total++;
        if (in_ready !== 1'b0) $display("FAIL bp_stall: got in_ready=%b, required 0", in_ready);
        else n_pass++;
        next_cycle();
        @(negedge clk);
        n_total++;
        if ({in_ready, blk_valid, blk_plaintext} !== {1'b0, 1'b1, PT1})
            $display("FAIL bp_hold: got rdy=%b vld=%b pt=%h, required 0 1 %h", in_ready, blk_valid, blk_plaintext, PT1);
        else n_pass++;
        next_cycle();
        blk_ready = 1'b1;
        sb32.push_back({PT2, KEY1});
        @(negedge clk);
        n_total++;
        if (in_ready !== 1'b1) $display("FAIL bp_release: got in_ready=%b, required 1", in_ready);
        else n_pass++;
        next_cycle();
        in_valid = 1'b0;
        @(negedge clk);
        n_total++;
        if ({blk_valid, blk_plaintext} !== {1'b1, PT2})
            $display("FAIL bp_no_gap: got vld=%b pt=%h, required 1 %h", blk_valid, blk_plaintext, PT2);
        else n_pass++;
        next_cycle();
        @(negedge clk);
        n_total++;
        if (blk_valid !== 1'b0) $display("FAIL bp_drained: got blk_valid=%b, required 0", blk_valid);
        else n_pass++;
        next_cycle();
    endtask

    task automatic test_mid_switch();
        logic [127:0] v;
        blk_ready = 1'b0;
        sb32.push_back({PT1, KEY1});
        send_block32(PT1, 1'b0);
        v = PT2;
        for (int i = 0; i < 2; i++) send_word32(v[127-32*i -: 32], 1'b0);
        v = KEY2;
        send_word32(v[127:96], 1'b1);
        @(negedge clk);
        n_total++;
        if (err_seq !== 1'b1) $display("FAIL seq_pulse: got err_seq=%b, required 1", err_seq);
        else n_pass++;
        next_cycle();
        @(negedge clk);
        n_total++;
        if (err_seq !== 1'b0) $display("FAIL seq_one_cycle: got err_seq=%b, required 0", err_seq);
        else n_pass++;
        next_cycle();
        for (int i = 1; i < 3; i++) send_word32(v[127-32*i -: 32], 1'b1);
        in_valid = 1'b1; in_data = v[31:0]; in_is_key = 1'b1;
        @(negedge clk);
        n_total++;
        if (in_ready !== 1'b0) $display("FAIL seq_key_stall: got in_ready=%b, required 0", in_ready);
        else n_pass++;
        next_cycle();
        blk_ready = 1'b1;
        next_cycle();
        in_valid = 1'b0;
        @(negedge clk);
        n_total++;
        if ({key_loaded, blk_valid, blk_key} !== {1'b1, 1'b0, KEY1})
            $display("FAIL seq_slot_untouched: got kl=%b vld=%b key=%h, required 1 0 %h",
                     key_loaded, blk_valid, blk_key, KEY1);
        else n_pass++;
        next_cycle();
        sb32.push_back({PT1, KEY2});
        send_block32(PT1, 1'b0);
        @(negedge clk);
        n_total++;
        if ({blk_valid, blk_key} !== {1'b1, KEY2})
            $display("FAIL seq_new_key: got vld=%b key=%h, required 1 %h", blk_valid, blk_key, KEY2);
        else n_pass++;
        next_cycle();
    endtask

    task automatic test_flush();
        logic [127:0] v;
        blk_ready = 1'b0;
        send_block32(PT2, 1'b0);
        v = PT1;
        for (int i = 0; i < 2; i++) send_word32(v[127-32*i -: 32], 1'b0);
        flush = 1'b1; in_valid = 1'b1; in_data = v[63:32]; in_is_key = 1'b0;
        next_cycle();
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        n_total++;
        if ({blk_valid, key_loaded} !== 2'b01)
            $display("FAIL flush_state: got vld/kl=%b, required 01", {blk_valid, key_loaded});
        else n_pass++;
        next_cycle();
        blk_ready = 1'b1;
        for (int i = 0; i < 3; i++) send_word32(v[127-32*i -: 32], 1'b0);
        @(negedge clk);
        n_total++;
        if (blk_valid !== 1'b0) $display("FAIL flush_idx_restart: got blk_valid=%b, required 0", blk_valid);
        else n_pass++;
        next_cycle();
        sb32.push_back({PT1, KEY2});
        send_word32(v[31:0], 1'b0);
        @(negedge clk);
        n_total++;
        if (blk_valid !== 1'b1) $display("FAIL flush_block: got blk_valid=%b, required 1", blk_valid);
        else n_pass++;
        next_cycle();
    endtask

    task automatic test_rst_mid();
        logic [127:0] v;
        v = PT2;
        blk_ready = 1'b1;
        for (int i = 0; i < 2; i++) send_word32(v[127-32*i -: 32], 1'b0);
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        n_total++;
        if ({key_loaded, blk_valid, in_ready} !== 3'b001)
            $display("FAIL rst_mid_state: got kl/vld/rdy=%b, required 001", {key_loaded, blk_valid, in_ready});
        else n_pass++;
        next_cycle();
        for (int i = 0; i < 3; i++) send_word32(v[127-32*i -: 32], 1'b0);
        @(negedge clk);
        n_total++;
        if (err_nokey !== 1'b0) $display("FAIL rst_mid_early: got err_nokey=%b, required 0", err_nokey);
        else n_pass++;
        next_cycle();
        send_word32(v[31:0], 1'b0);
        @(negedge clk);
        n_total++;
        if (err_nokey !== 1'b1) $display("FAIL rst_mid_nokey: got err_nokey=%b, required 1", err_nokey);
        else n_pass++;
        next_cycle();
    endtask

    task automatic test_width8();
        b_blk_ready = 1'b1;
        send_block8(KEY1, 1'b1);
        @(negedge clk);
        n_total++;
        if ({b_key_loaded, b_blk_valid} !== 2'b10)
            $display("FAIL w8_key: got kl/vld=%b, required 10", {b_key_loaded, b_blk_valid});
        else n_pass++;
        next_cycle();
        sb8.push_back({PT1, KEY1});
        sb8.push_back({PT1, KEY1});
        send_block8(PT1, 1'b0);
        send_block8(PT1, 1'b0);
        @(negedge clk);
        n_total++;
        if (b_blk_valid !== 1'b1) $display("FAIL w8_second: got blk_valid=%b, required 1", b_blk_valid);
        else n_pass++;
        next_cycle();
        n_total++;
        if (pop8_t.size() != 2)
            $display("FAIL w8_count: got %0d blocks, required 2", pop8_t.size());
        else if (pop8_t[1] - pop8_t[0] != 160)
            $display("FAIL w8_spacing: got %0t, required 160", pop8_t[1] - pop8_t[0]);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_no_key();
        test_key_load();
        test_backpressure();
        test_mid_switch();
        test_flush();
        test_rst_mid();
        test_width8();
        repeat (2) next_cycle();
        n_total++;
        if (sb32.size() != 0 || sb8.size() != 0)
            $display("FAIL sb_leftover: got %0d/%0d pending, required 0/0", sb32.size(), sb8.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
